bb_responder: RTL and testbench

- Target end of the 8-bit parity-protected byte bus that the core drives on oib_clk/ob_data/ob_pty and samples on ib_data/ib_pty.
- Deserialises initiator frames into single 32-bit local bus transactions (wishbone-classic style master port).
- Serialises ack/read-data/error responses back to the initiator.
- Sits at the far end of the link, for example in the companion FPGA or a test harness, clocked by the forwarded oib_clk.

---
 rtl/bb_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_bb_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_responder.sv
// bb_responder: target end of the 8-bit odd-parity byte bus.
// It turns initiator frames into single 32-bit local-bus transactions and
// serialises ack, read-data and error responses back to the initiator.
// It runs on the forwarded oib_clk.
//
// Ports:
//   oib_clk    forwarded bus clock; all logic runs on the rising edge
//   ext_rst_n  asynchronous active-low reset
//   ob_data    outbound byte from the initiator
//   ob_pty     odd parity bit for ob_data
//   ib_data    response byte to the initiator
//   ib_pty     odd parity bit for ib_data
//   m_cyc      local bus cycle/strobe
//   m_we       local bus write enable
//   m_sel      local bus byte selects
//   m_adr      local bus address
//   m_dat_o    local bus write data
//   m_dat_i    local bus read data
//   m_ack      local bus acknowledge
//   perr_cnt   saturating count of outbound parity errors
//
// state | meaning
// IDLE  | waiting for a header byte (bit7=1); idle bytes are ignored
// ADDR  | shifting in 4 address bytes, LSB first
// WDATA | shifting in 4 write-data bytes, LSB first (writes only)
// BUS   | m_cyc asserted, waiting for m_ack or timeout
// RESP  | response code on ib_data, then read-data bytes if any
// ERR   | frame discarded after a parity error, waiting for a good idle byte

module bb_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic        oib_clk,
  input  logic        ext_rst_n,
  input  logic [7:0]  ob_data,
  input  logic        ob_pty,
  output logic [7:0]  ib_data,
  output logic        ib_pty,
  output logic        m_cyc,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [31:0] m_adr,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack,
  output logic [7:0]  perr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  RSP_ACK  = 8'h80;
  localparam logic [7:0]  RSP_PERR = 8'hA0;
  localparam logic [7:0]  RSP_TMO  = 8'hA1;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dato_q, dato_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  ib_q, ib_d;
  logic        cyc_q, cyc_d;
  logic [7:0]  perr_q, perr_d;
  logic [2:0]  left_q, left_d;

  logic        byte_good;
  logic [7:0]  perr_inc;

  assign byte_good = ^{ob_pty, ob_data};
  assign perr_inc  = (perr_q == 8'hFF) ? perr_q : perr_q + 8'd1;

  always_ff @(posedge oib_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      dato_q  <= 32'h0;
      rdata_q <= 32'h0;
      tmo_q   <= 16'h0;
      ib_q    <= 8'h00;
      cyc_q   <= 1'b0;
      perr_q  <= 8'h00;
      left_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dato_q  <= dato_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      ib_q    <= ib_d;
      cyc_q   <= cyc_d;
      perr_q  <= perr_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dato_d  = dato_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    ib_d    = 8'h00;
    cyc_d   = cyc_q;
    perr_d  = perr_q;
    left_d  = left_q;

    case (state_q)
      S_IDLE: begin
        if (!byte_good) begin
          perr_d = perr_inc;
        end else if (ob_data[7]) begin
          we_d    = ob_data[6];
          sel_d   = ob_data[3:0];
          cnt_d   = 2'd0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (!byte_good) begin
          perr_d  = perr_inc;
          state_d = S_ERR;
        end else begin
          // LSB-first: each new byte enters at the top and moves down.
          adr_d = {ob_data, adr_q[31:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_BUS;
              cyc_d   = 1'b1;
              tmo_d   = 16'h0;
            end
          end
        end
      end

      S_WDATA: begin
        if (!byte_good) begin
          perr_d  = perr_inc;
          state_d = S_ERR;
        end else begin
          dato_d = {ob_data, dato_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            tmo_d   = 16'h0;
          end
        end
      end

      S_BUS: begin
        // An ack in the expiry cycle wins over the timeout.
        if (m_ack) begin
          cyc_d   = 1'b0;
          ib_d    = RSP_ACK;
          state_d = S_RESP;
          if (!we_q) begin
            rdata_d = m_dat_i;
            left_d  = 3'd4;
          end else begin
            left_d  = 3'd0;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d   = 1'b0;
          ib_d    = RSP_TMO;
          left_d  = 3'd0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_RESP: begin
        // ib_q is showing the code or a data byte; queue the next one.
        if (left_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          ib_d    = rdata_q[7:0];
          rdata_d = {8'h00, rdata_q[31:8]};
          left_d  = left_q - 3'd1;
        end
      end

      S_ERR: begin
        if (!byte_good) begin
          perr_d = perr_inc;
        end else if (!ob_data[7]) begin
          ib_d    = RSP_PERR;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  assign ib_data  = ib_q;
  assign ib_pty   = ~^ib_q;
  assign m_cyc    = cyc_q;
  assign m_we     = we_q;
  assign m_sel    = sel_q;
  assign m_adr    = adr_q;
  assign m_dat_o  = dato_q;
  assign perr_cnt = perr_q;

endmodule

// File: tb/tb_bb_responder.sv
// Testbench for bb_responder: cycle-by-cycle vector tables for the normal
// frames, plus hand sequences for timeout, reset and saturation.
module tb_bb_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ob_data;
  logic        ob_pty;
  logic [7:0]  ib_data;
  logic        ib_pty;
  logic        m_cyc;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_ack;
  logic [7:0]  perr_cnt;

  always #5 clk = ~clk;

  bb_responder #(.TIMEOUT(8)) dut (
    .oib_clk   (clk),
    .ext_rst_n (rst_n),
    .ob_data   (ob_data),
    .ob_pty    (ob_pty),
    .ib_data   (ib_data),
    .ib_pty    (ib_pty),
    .m_cyc     (m_cyc),
    .m_we      (m_we),
    .m_sel     (m_sel),
    .m_adr     (m_adr),
    .m_dat_o   (m_dat_o),
    .m_dat_i   (m_dat_i),
    .m_ack     (m_ack),
    .perr_cnt  (perr_cnt)
  );

  typedef struct {
    logic [7:0] ob;
    logic       bad;
    logic       ack;
    logic [7:0] eib;
    logic       ecyc;
    logic [7:0] eperr;
  } vec_t;

  vec_t        vq[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_perr;
  logic        exp_we;
  logic [3:0]  exp_sel;
  logic [31:0] exp_adr;
  logic [31:0] exp_dato;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic bad);
    ob_data = b;
    ob_pty  = (~^b) ^ bad;
  endtask

  task automatic add(input logic [7:0] ob, input logic bad, input logic ack,
                     input logic [7:0] eib, input logic ecyc);
    vec_t v;
    v.ob = ob; v.bad = bad; v.ack = ack; v.eib = eib; v.ecyc = ecyc;
    v.eperr = exp_perr;
    vq.push_back(v);
  endtask

  // Row i: outputs are checked in cycle i, then cycle i's inputs are driven.
  task automatic run_vec(input string tag);
    foreach (vq[i]) begin
      @(negedge clk);
      chk($sformatf("%s[%0d] ib_data", tag, i), ib_data, vq[i].eib);
      chk($sformatf("%s[%0d] ib_pty", tag, i), ib_pty, ~^vq[i].eib);
      chk($sformatf("%s[%0d] m_cyc", tag, i), m_cyc, vq[i].ecyc);
      chk($sformatf("%s[%0d] perr_cnt", tag, i), perr_cnt, vq[i].eperr);
      if (vq[i].ecyc) begin
        chk($sformatf("%s[%0d] m_we", tag, i), m_we, exp_we);
        chk($sformatf("%s[%0d] m_sel", tag, i), m_sel, exp_sel);
        chk($sformatf("%s[%0d] m_adr", tag, i), m_adr, exp_adr);
        if (exp_we) chk($sformatf("%s[%0d] m_dat_o", tag, i), m_dat_o, exp_dato);
      end
      drive(vq[i].ob, vq[i].bad);
      m_ack = vq[i].ack;
    end
    vq.delete();
  endtask

  task automatic write_rows();
    exp_we = 1'b1; exp_sel = 4'hF; exp_adr = 32'h12345678; exp_dato = 32'hAABBCCDD;
    add(8'hCF, 0, 0, 8'h00, 0);
    add(8'h78, 0, 0, 8'h00, 0);
    add(8'h56, 0, 0, 8'h00, 0);
    add(8'h34, 0, 0, 8'h00, 0);
    add(8'h12, 0, 0, 8'h00, 0);
    add(8'hDD, 0, 0, 8'h00, 0);
    add(8'hCC, 0, 0, 8'h00, 0);
    add(8'hBB, 0, 0, 8'h00, 0);
    add(8'hAA, 0, 0, 8'h00, 0);
    add(8'h00, 0, 1, 8'h00, 1);
    add(8'h00, 0, 0, 8'h80, 0);
    add(8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic read_rows();
    exp_we = 1'b0; exp_sel = 4'h3; exp_adr = 32'h00001000;
    m_dat_i = 32'hCAFEF00D;
    add(8'h83, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 8'h00, 0);
    add(8'h10, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 8'h00, 1);
    add(8'h00, 0, 0, 8'h00, 1);
    add(8'h00, 0, 0, 8'h00, 1);
    add(8'h00, 0, 1, 8'h00, 1);
    add(8'h00, 0, 0, 8'h80, 0);
    add(8'h00, 0, 0, 8'h0D, 0);
    add(8'h00, 0, 0, 8'hF0, 0);
    add(8'h00, 0, 0, 8'hFE, 0);
    add(8'h00, 0, 0, 8'hCA, 0);
    add(8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ib_data"}, ib_data, 32'h00);
    chk({tag, " ib_pty"}, ib_pty, 32'h1);
    chk({tag, " m_cyc"}, m_cyc, 32'h0);
    chk({tag, " m_we"}, m_we, 32'h0);
    chk({tag, " m_sel"}, m_sel, 32'h0);
    chk({tag, " m_adr"}, m_adr, 32'h0);
    chk({tag, " m_dat_o"}, m_dat_o, 32'h0);
    chk({tag, " perr_cnt"}, perr_cnt, 32'h0);
  endtask

  initial begin
    int cyc_cnt, a1_cnt, a1_idx, last_cyc_idx, other_nz, nz;
    logic seen;

    rst_n = 1'b0;
    m_ack = 1'b0;
    m_dat_i = 32'h0;
    drive(8'h00, 0);
    exp_perr = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    write_rows();
    run_vec("write");
    read_rows();
    run_vec("read");

    // Parity error on address byte 2, frame abandoned with an idle byte.
    exp_sel = 4'h3;
    add(8'h83, 0, 0, 8'h00, 0);
    add(8'h78, 0, 0, 8'h00, 0);
    add(8'h56, 1, 0, 8'h00, 0);
    exp_perr = 8'h01;
    add(8'h00, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 8'hA0, 0);
    add(8'h00, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 8'h00, 0);
    run_vec("perr");
    write_rows();
    run_vec("after_perr");

    // Timeout: read with no ack, TIMEOUT=8.
    @(negedge clk); drive(8'h80, 0);
    @(negedge clk); drive(8'h00, 0);
    @(negedge clk); drive(8'h10, 0);
    @(negedge clk); drive(8'h00, 0);
    @(negedge clk); drive(8'h00, 0);
    cyc_cnt = 0; a1_cnt = 0; a1_idx = -1; last_cyc_idx = -1; other_nz = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      drive(8'h00, 0);
      if (m_cyc) begin cyc_cnt++; last_cyc_idx = k; end
      if (ib_data == 8'hA1) begin a1_cnt++; a1_idx = k; end
      else if (ib_data != 8'h00) other_nz++;
    end
    chk("tmo m_cyc cycles", cyc_cnt, 8);
    chk("tmo A1 count", a1_cnt, 1);
    chk("tmo A1 follows m_cyc", a1_idx, last_cyc_idx + 1);
    chk("tmo other bytes", other_nz, 0);
    write_rows();
    run_vec("after_tmo");

    // Reset during WDATA byte 2.
    @(negedge clk); drive(8'hCF, 0);
    @(negedge clk); drive(8'h78, 0);
    @(negedge clk); drive(8'h56, 0);
    @(negedge clk); drive(8'h34, 0);
    @(negedge clk); drive(8'h12, 0);
    @(negedge clk); drive(8'hDD, 0);
    @(negedge clk); drive(8'hCC, 0);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_wdata");
    exp_perr = 8'h00;
    @(negedge clk); drive(8'h00, 0); rst_n = 1'b1;

    // Reset while the bus cycle is open.
    @(negedge clk); drive(8'h83, 0);
    @(negedge clk); drive(8'h00, 0);
    @(negedge clk); drive(8'h10, 0);
    @(negedge clk); drive(8'h00, 0);
    @(negedge clk); drive(8'h00, 0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (m_cyc) seen = 1'b1;
    end
    chk("rst_bus m_cyc seen", seen, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_bus");
    @(negedge clk); rst_n = 1'b1;
    read_rows();
    run_vec("after_rst");

    // Saturation: 300 bad-parity idle bytes.
    nz = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      drive(8'h00, 1);
      if (ib_data != 8'h00) nz++;
      if (k == 200) chk("sat perr mid", perr_cnt, 200);
    end
    @(negedge clk); drive(8'h00, 0);
    if (ib_data != 8'h00) nz++;
    @(negedge clk);
    chk("sat perr_cnt", perr_cnt, 8'hFF);
    chk("sat no response", nz, 0);
    chk("sat m_cyc", m_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
